// File: rtl/mode_sequencer_if.sv
// Key/mode bundle between the calculator top level and the mode sequencer.
interface mode_sequencer_if;
    logic [1:0] key_n;
    logic [1:0] mode;
    logic       mode_changed;
    logic [1:0] key_db;

    modport master (output key_n, input mode, input mode_changed, input key_db);
    modport slave  (input key_n, output mode, output mode_changed, output key_db);
endinterface

// File: rtl/mode_sequencer.sv
// Debounced KEY[1:0] controller stepping the calculator MODE select.
// Optional KEY0 auto-repeat is enabled by defining MODE_AUTOREPEAT_EN.
module mode_sequencer #(
    parameter int DEBOUNCE_TICKS = 500000,
    parameter int HOLD_TICKS     = 25000000,
    parameter int REPEAT_TICKS   = 12500000
) (
    input  logic            clk,
    input  logic            rst,
    mode_sequencer_if.slave bus
);

    // One counter width covers debounce, hold and repeat intervals.
    localparam int MAX_DH    = (DEBOUNCE_TICKS > HOLD_TICKS) ? DEBOUNCE_TICKS : HOLD_TICKS;
    localparam int MAX_TICKS = (MAX_DH > REPEAT_TICKS) ? MAX_DH : REPEAT_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);

`ifdef MODE_AUTOREPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {IDLE, HELD, HOLD_WAIT, REPEAT} state_t;
    logic [CW-1:0] tick_cnt;
`else
    typedef enum logic {IDLE, HELD} state_t;
`endif

    state_t            state;
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        pressed_sync;
    logic [1:0][CW-1:0] db_cnt;
    logic [1:0]        key_db_r;
    logic [1:0]        key_db_d;
    logic [1:0]        press;
    logic [1:0]        mode_r;
    logic [1:0]        step_mode;
    logic              mode_changed_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
        end
    end

    assign pressed_sync = ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            key_db_r <= 2'b00;
            key_db_d <= 2'b00;
        end else begin
            key_db_d <= key_db_r;
            for (int k = 0; k < 2; k++) begin
                if (pressed_sync[k] == key_db_r[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    key_db_r[k] <= pressed_sync[k];
                    db_cnt[k]   <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press = key_db_r & ~key_db_d;

    always_comb begin
        step_mode = mode_r;
        case (press)
            2'b01:   step_mode = mode_r + 2'd1;
            2'b10:   step_mode = mode_r - 2'd1;
            2'b11:   step_mode = 2'd0;
            default: step_mode = mode_r;
        endcase
    end

    // A fresh press edge steps mode in IDLE or HELD; holding alone never steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mode_r         <= 2'd0;
            mode_changed_r <= 1'b0;
`ifdef MODE_AUTOREPEAT_EN
            tick_cnt       <= '0;
`endif
        end else begin
            mode_changed_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (press != 2'b00) begin
                        mode_r         <= step_mode;
                        mode_changed_r <= (step_mode != mode_r);
`ifdef MODE_AUTOREPEAT_EN
                        if (press == 2'b01 && key_db_r == 2'b01) begin
                            state    <= HOLD_WAIT;
                            tick_cnt <= '0;
                        end else begin
                            state <= HELD;
                        end
`else
                        state <= HELD;
`endif
                    end
                end
                HELD: begin
                    if (press != 2'b00) begin
                        mode_r         <= step_mode;
                        mode_changed_r <= (step_mode != mode_r);
                    end
                    if (key_db_r == 2'b00) begin
                        state <= IDLE;
                    end
                end
`ifdef MODE_AUTOREPEAT_EN
                HOLD_WAIT: begin
                    if (key_db_r != 2'b01) begin
                        state <= HELD;
                    end else if (tick_cnt == HOLD_LAST) begin
                        state          <= REPEAT;
                        tick_cnt       <= '0;
                        mode_r         <= mode_r + 2'd1;
                        mode_changed_r <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (key_db_r != 2'b01) begin
                        state <= HELD;
                    end else if (tick_cnt == REPEAT_LAST) begin
                        tick_cnt       <= '0;
                        mode_r         <= mode_r + 2'd1;
                        mode_changed_r <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mode         = mode_r;
    assign bus.mode_changed = mode_changed_r;
    assign bus.key_db       = key_db_r;

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: stimulus queues expected strobes, a monitor checks them.
module tb_mode_sequencer;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
`ifdef MODE_AUTOREPEAT_EN
    localparam logic [1:0] MODE_AFTER_HOLD = 2'd2;
`else
    localparam logic [1:0] MODE_AFTER_HOLD = 2'd1;
`endif

    typedef struct {
        logic [1:0] mode;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mode_sequencer_if bus();

    mode_sequencer #(
        .DEBOUNCE_TICKS(DB),
        .HOLD_TICKS    (HOLD),
        .REPEAT_TICKS  (REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input logic [1:0] m, input int c);
        exp_t e;
        e.mode = m;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Press the keys in low_mask for low_cycles, release and let the release debounce.
    task automatic applyStimulus(input logic [1:0] low_mask, input int low_cycles,
                                 input logic strobe_exp, input logic [1:0] mode_exp);
        @(negedge clk);
        bus.key_n = ~low_mask;
        if (strobe_exp) pushExp(mode_exp, cyc + 7);
        repeat (low_cycles) @(negedge clk);
        bus.key_n = 2'b11;
        repeat (12) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL missed strobe: no strobe seen, required mode %0d at cycle %0d (now %0d)",
                     exp_q[0].mode, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (bus.mode_changed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected strobe: mode %0d at cycle %0d, required no strobe", bus.mode, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.mode !== mon_e.mode || cyc != mon_e.cyc) begin
                    failures++;
                    $display("[TB] FAIL strobe: got mode %0d at cycle %0d, required mode %0d at cycle %0d",
                             bus.mode, cyc, mon_e.mode, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        rst       = 1'b1;
        bus.key_n = 2'b11;
        repeat (3) @(negedge clk);
        checkOutput("reset mode", bus.mode, 2'd0);
        checkOutput("reset mode_changed", {1'b0, bus.mode_changed}, 2'd0);
        checkOutput("reset key_db", bus.key_db, 2'b00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] KEY0 press, latency and strobe width");
        @(negedge clk);
        c0 = cyc;
        bus.key_n = 2'b10;
        pushExp(2'd1, c0 + 7);
        repeat (5) @(negedge clk);
        checkOutput("key_db before accept", bus.key_db, 2'b00);
        @(negedge clk);
        checkOutput("key_db at accept", bus.key_db, 2'b01);
        checkOutput("mode before step", bus.mode, 2'd0);
        @(negedge clk);
        checkOutput("mode after step", bus.mode, 2'd1);
        @(negedge clk);
        checkOutput("strobe width", {1'b0, bus.mode_changed}, 2'd0);
        repeat (12) @(negedge clk);
        bus.key_n = 2'b11;
        repeat (12) @(negedge clk);
        checkOutput("key_db released", bus.key_db, 2'b00);

        $display("[TB] glitch rejection");
        applyStimulus(2'b01, 3, 1'b0, 2'd0);
        checkOutput("glitch mode", bus.mode, 2'd1);
        checkOutput("glitch key_db", bus.key_db, 2'b00);

        $display("[TB] KEY1 down steps and wraps");
        applyStimulus(2'b10, 10, 1'b1, 2'd0);
        applyStimulus(2'b10, 10, 1'b1, 2'd3);
        checkOutput("wrap down", bus.mode, 2'd3);
        applyStimulus(2'b01, 10, 1'b1, 2'd0);
        checkOutput("wrap up", bus.mode, 2'd0);

        $display("[TB] both keys reset mode");
        applyStimulus(2'b01, 10, 1'b1, 2'd1);
        applyStimulus(2'b01, 10, 1'b1, 2'd2);
        applyStimulus(2'b11, 10, 1'b1, 2'd0);
        checkOutput("both from 2", bus.mode, 2'd0);
        applyStimulus(2'b11, 10, 1'b0, 2'd0);
        checkOutput("both from 0", bus.mode, 2'd0);

        $display("[TB] long KEY0 hold");
        @(negedge clk);
        c0 = cyc;
        bus.key_n = 2'b10;
        pushExp(2'd1, c0 + 7);
`ifdef MODE_AUTOREPEAT_EN
        pushExp(2'd2, c0 + 27);
        pushExp(2'd3, c0 + 35);
        pushExp(2'd0, c0 + 43);
        pushExp(2'd1, c0 + 51);
        pushExp(2'd2, c0 + 59);
`endif
        repeat (60) @(negedge clk);
        bus.key_n = 2'b11;
        repeat (14) @(negedge clk);
        checkOutput("mode after hold", bus.mode, MODE_AFTER_HOLD);

        $display("[TB] reset mid-hold");
        @(negedge clk);
        c0 = cyc;
        bus.key_n = 2'b10;
        pushExp(2'(MODE_AFTER_HOLD + 2'd1), c0 + 7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-hold reset mode", bus.mode, 2'd0);
        checkOutput("mid-hold reset strobe", {1'b0, bus.mode_changed}, 2'd0);
        checkOutput("mid-hold reset key_db", bus.key_db, 2'b00);
        rst = 1'b0;
        pushExp(2'd1, cyc + 7);
        repeat (10) @(negedge clk);
        bus.key_n = 2'b11;
        repeat (12) @(negedge clk);
        checkOutput("re-debounced step", bus.mode, 2'd1);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
